pe_sequencer: RTL and testbench
===============================

// Module: pe_sequencer
// PURPOSE
//   Control FSM for one PE datapath. It loads the 4x4 filter and middle-buffer rows from memory through a req/ack port.
//   It sequences window load, 16-step MAC, result push and buffer shift, and hands each full 4-result word to a
//   valid/ready consumer. It sits beside the PE datapath and drives every strobe; the datapath returns mbcZero/raDone/rbFull.
// PARAMETERS
//   ADDR_W       16   memory word-address width
//   TIMEOUT_CYC  255  ack watchdog limit in cycles (PE_SEQ_TIMEOUT_EN only)
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous, active-low reset
//   start        in   1       1-cycle pulse; accepted only in IDLE
//   abort        in   1       synchronous abort, any state
//   filBase      in   ADDR_W  filter base address, latched on start
//   imgBase      in   ADDR_W  image base address, latched on start
//   numStrips    in   8       strips to process, latched on start
//   memReq       out  1       memory read request
//   memAddr      out  ADDR_W  read address, held stable while memReq=1
//   memAck       in   1       memIn valid this cycle; completes the request
//   mbcZero, raDone, rbFull  in  1  datapath status
//   fblRst fblAct filBufRst filBufLd fillBufISel mbRst mbShift mbWrite mblRst mblAct
//   mbcRst mbcEn wbRst wbLd raAct macRst macAct rbRst rbEn macClear rbClear   out 1 each  datapath strobes
//   resValid     out  1       resBufOut holds a full result word
//   resReady     in   1       consumer accepts the word
//   busy         out  1       1 in every state except IDLE
//   done         out  1       1-cycle pulse at job end
//   err          out  1       sticky watchdog error (0 when the feature is off)
// BEHAVIOUR
//   Reset (rst=0): state IDLE; every output 0; address pointers and strip counter 0.
//   Outputs decode from the registered state. Load strobes are also gated by memAck.
//   States:
//   - IDLE: start -> INIT. Latch bases and numStrips; filPtr=filBase, imgPtr=imgBase.
//   - INIT (1 cycle): assert all eight *Rst strobes. If numStrips==0 -> DONE with no memory traffic; else -> FIL.
//   - FIL: memReq=1, memAddr=filPtr. On memAck: filBufLd=fblAct=fillBufISel=1, filPtr++.
//     The 4th ack -> MBF.
//   - MBF: memReq=1, memAddr=imgPtr. On memAck: mbWrite=mblAct=1, imgPtr++. The 4th ack -> WIN.
//   - WIN (1 cycle): wbLd=1 -> MAC.
//   - MAC: raAct=macAct=1, fillBufISel=0, one (i,j) step per cycle. The cycle with raDone=1 is the last step -> PUSH.
//     Exactly 16 MAC cycles.
//   - PUSH (1 cycle): rbEn=1 -> NXT.
//   - NXT (1 cycle): macClear=1, evaluated in priority order:
//     1. rbFull -> OUT.
//     2. mbcZero -> MBF (refill 4 rows; mblRst=1 this cycle).
//     3. Otherwise mbShift=mbcEn=1 -> WIN.
//   - OUT: resValid=1, held until resReady. Transfer cycle: rbClear=1, strip counter++.
//     If the counter == numStrips -> DONE; else mbcRst=mblRst=1 -> MBF.
//   - DONE (1 cycle): done=1 -> IDLE.
//   Boundaries:
//   - start while busy is ignored.
//   - A memAck with memReq=0 is ignored.
//   - memReq is never dropped before its ack.
//   - abort=1 takes priority over every transition:
//     1. Next state is IDLE.
//     2. memReq drops next cycle.
//     3. All *Rst strobes pulse 1 cycle.
//     4. No done pulse is issued.
//   - resValid stays 1 until resReady; the result word is never lost.
//   - Pointers wrap modulo 2^ADDR_W.
//   - The strip counter is compared at equality, so numStrips=255 is legal.
// CONFIGURATION
//   PE_SEQ_TIMEOUT_EN defined:
//   - A counter runs while memReq=1 and no memAck arrives; it clears on each ack.
//   - On reaching TIMEOUT_CYC: go to IDLE, set err=1, drop memReq.
//   - err stays 1 until the next accepted start clears it.
//   PE_SEQ_TIMEOUT_EN undefined: the controller waits for memAck indefinitely; err is tied 0 and no counter is built.
// TESTING
//   1. Reset mid-MAC: assert rst=0 -> all outputs 0 immediately; after release, start is accepted from IDLE.
//   2. numStrips=1, ack every cycle:
//      - 4 reads at filBase..+3, then 4 reads at imgBase..+3.
//      - Four groups of WIN, 16-cycle MAC, PUSH.
//      - resValid, then a single 1-cycle done pulse.
//   3. Hold resReady=0 for 10 cycles in OUT -> resValid stays 1, rbClear stays 0.
//      Raise resReady -> one rbClear pulse.
//   4. numStrips=0 -> INIT then DONE: memReq never asserts, done pulses 2 cycles after start.
//   5. Random ack gaps of 0-5 cycles -> memAddr stays stable while memReq=1; sequence and result count unchanged.
//   6. Abort during MBF, then (PE_SEQ_TIMEOUT_EN, TIMEOUT_CYC=8) no ack:
//      - Abort: return to IDLE with a reset pulse and no done.
//      - Timeout: err=1 after 8 unacked cycles; err clears on the next start.

Source files
------------

// File: rtl/pe_sequencer.sv
// pe_sequencer: control FSM for one PE datapath.
// Loads the 4x4 filter and middle-buffer rows through a req/ack memory port,
// sequences window load / 16-step MAC / result push / buffer shift, and hands
// each full result word to a valid/ready consumer.
// Optional feature macro: PE_SEQ_TIMEOUT_EN builds an ack watchdog that aborts
// the job after TIMEOUT_CYC unacknowledged request cycles and raises a sticky err.
module pe_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] filBase,
    input  logic [ADDR_W-1:0] imgBase,
    input  logic [7:0]        numStrips,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memAck,
    input  logic              mbcZero,
    input  logic              raDone,
    input  logic              rbFull,
    output logic              fblRst,
    output logic              fblAct,
    output logic              filBufRst,
    output logic              filBufLd,
    output logic              fillBufISel,
    output logic              mbRst,
    output logic              mbShift,
    output logic              mbWrite,
    output logic              mblRst,
    output logic              mblAct,
    output logic              mbcRst,
    output logic              mbcEn,
    output logic              wbRst,
    output logic              wbLd,
    output logic              raAct,
    output logic              macRst,
    output logic              macAct,
    output logic              rbRst,
    output logic              rbEn,
    output logic              macClear,
    output logic              rbClear,
    output logic              resValid,
    input  logic              resReady,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_INIT = 4'd1,
        S_FIL  = 4'd2,
        S_MBF  = 4'd3,
        S_WIN  = 4'd4,
        S_MAC  = 4'd5,
        S_PUSH = 4'd6,
        S_NXT  = 4'd7,
        S_OUT  = 4'd8,
        S_DONE = 4'd9
    } state_t;

    state_t            state_r;
    state_t            state_fsm_s;
    state_t            state_nx_s;
    logic [ADDR_W-1:0] fil_ptr_r;
    logic [ADDR_W-1:0] img_ptr_r;
    logic [7:0]        num_strips_r;
    logic [7:0]        strip_cnt_r;
    logic [1:0]        ld_cnt_r;
    logic              abort_r;
    logic              load_ack_s;
    logic              last_strip_s;
    logic              start_ok_s;
    logic              timeout_s;

    // Only an ack that lands in a load state completes a request.
    assign load_ack_s   = memAck && ((state_r == S_FIL) || (state_r == S_MBF));
    assign last_strip_s = ((strip_cnt_r + 8'd1) == num_strips_r);
    assign start_ok_s   = (state_r == S_IDLE) && start && !abort;

`ifdef PE_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_r;
    logic            err_r;

    assign timeout_s = memReq && !memAck && (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));
    assign err       = err_r;

    // Watchdog: count consecutive unacked request cycles, clear on ack or idle bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (memReq && !memAck && !abort && !timeout_s) begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            to_cnt_r <= {TO_W{1'b0}};
        end
    end

    // Sticky error: set on watchdog expiry, cleared by the next accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (timeout_s && !abort) begin
            err_r <= 1'b1;
        end else if (start_ok_s) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Remember an abort so the reset strobes fire in the following IDLE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            abort_r <= 1'b0;
        end else begin
            abort_r <= abort;
        end
    end

    // Job context: latched bases, address pointers, load beat and strip counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fil_ptr_r    <= {ADDR_W{1'b0}};
            img_ptr_r    <= {ADDR_W{1'b0}};
            num_strips_r <= 8'd0;
            strip_cnt_r  <= 8'd0;
            ld_cnt_r     <= 2'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_ok_s) begin
                        fil_ptr_r    <= filBase;
                        img_ptr_r    <= imgBase;
                        num_strips_r <= numStrips;
                        strip_cnt_r  <= 8'd0;
                        ld_cnt_r     <= 2'd0;
                    end
                end
                S_FIL: begin
                    if (load_ack_s) begin
                        fil_ptr_r <= fil_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        ld_cnt_r  <= ld_cnt_r + 2'd1;
                    end
                end
                S_MBF: begin
                    if (load_ack_s) begin
                        img_ptr_r <= img_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        ld_cnt_r  <= ld_cnt_r + 2'd1;
                    end
                end
                S_OUT: begin
                    if (resReady) begin
                        strip_cnt_r <= strip_cnt_r + 8'd1;
                    end
                end
                default: begin
                    strip_cnt_r <= strip_cnt_r;
                end
            endcase
        end
    end

    // Next-state logic; abort beats the watchdog, which beats normal sequencing.
    always_comb begin
        state_fsm_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_fsm_s = S_INIT;
                else       state_fsm_s = S_IDLE;
            end
            S_INIT: begin
                if (num_strips_r == 8'd0) state_fsm_s = S_DONE;
                else                      state_fsm_s = S_FIL;
            end
            S_FIL: begin
                if (load_ack_s && (ld_cnt_r == 2'd3)) state_fsm_s = S_MBF;
                else                                  state_fsm_s = S_FIL;
            end
            S_MBF: begin
                if (load_ack_s && (ld_cnt_r == 2'd3)) state_fsm_s = S_WIN;
                else                                  state_fsm_s = S_MBF;
            end
            S_WIN:  state_fsm_s = S_MAC;
            S_MAC: begin
                if (raDone) state_fsm_s = S_PUSH;
                else        state_fsm_s = S_MAC;
            end
            S_PUSH: state_fsm_s = S_NXT;
            S_NXT: begin
                if (rbFull)       state_fsm_s = S_OUT;
                else if (mbcZero) state_fsm_s = S_MBF;
                else              state_fsm_s = S_WIN;
            end
            S_OUT: begin
                if (!resReady)        state_fsm_s = S_OUT;
                else if (last_strip_s) state_fsm_s = S_DONE;
                else                   state_fsm_s = S_MBF;
            end
            S_DONE:  state_fsm_s = S_IDLE;
            default: state_fsm_s = S_IDLE;
        endcase

        if (abort)          state_nx_s = S_IDLE;
        else if (timeout_s) state_nx_s = S_IDLE;
        else                state_nx_s = state_fsm_s;
    end

    // Strobe decode from the registered state; load strobes qualified by memAck.
    always_comb begin
        memReq      = 1'b0;
        memAddr     = {ADDR_W{1'b0}};
        fblRst      = 1'b0;
        fblAct      = 1'b0;
        filBufRst   = 1'b0;
        filBufLd    = 1'b0;
        fillBufISel = 1'b0;
        mbRst       = 1'b0;
        mbShift     = 1'b0;
        mbWrite     = 1'b0;
        mblRst      = 1'b0;
        mblAct      = 1'b0;
        mbcRst      = 1'b0;
        mbcEn       = 1'b0;
        wbRst       = 1'b0;
        wbLd        = 1'b0;
        raAct       = 1'b0;
        macRst      = 1'b0;
        macAct      = 1'b0;
        rbRst       = 1'b0;
        rbEn        = 1'b0;
        macClear    = 1'b0;
        rbClear     = 1'b0;
        resValid    = 1'b0;
        done        = 1'b0;
        busy        = (state_r != S_IDLE);
        case (state_r)
            S_IDLE, S_INIT: begin
                if ((state_r == S_INIT) || abort_r) begin
                    fblRst    = 1'b1;
                    filBufRst = 1'b1;
                    mbRst     = 1'b1;
                    mblRst    = 1'b1;
                    mbcRst    = 1'b1;
                    wbRst     = 1'b1;
                    macRst    = 1'b1;
                    rbRst     = 1'b1;
                end else begin
                    fblRst    = 1'b0;
                end
            end
            S_FIL: begin
                memReq      = 1'b1;
                memAddr     = fil_ptr_r;
                filBufLd    = memAck;
                fblAct      = memAck;
                fillBufISel = memAck;
            end
            S_MBF: begin
                memReq  = 1'b1;
                memAddr = img_ptr_r;
                mbWrite = memAck;
                mblAct  = memAck;
            end
            S_WIN:  wbLd = 1'b1;
            S_MAC: begin
                raAct  = 1'b1;
                macAct = 1'b1;
            end
            S_PUSH: rbEn = 1'b1;
            S_NXT: begin
                macClear = 1'b1;
                if (rbFull) begin
                    mblRst = 1'b0;
                end else if (mbcZero) begin
                    mblRst = 1'b1;
                end else begin
                    mbShift = 1'b1;
                    mbcEn   = 1'b1;
                end
            end
            S_OUT: begin
                resValid = 1'b1;
                if (resReady) begin
                    rbClear = 1'b1;
                    mbcRst  = !last_strip_s;
                    mblRst  = !last_strip_s;
                end else begin
                    rbClear = 1'b0;
                end
            end
            S_DONE:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed self-checking bench for pe_sequencer with a small datapath stand-in
// (MAC step counter, result-buffer fill counter, shift counter) and a memory
// responder with optional random ack gaps. Build with PE_SEQ_TIMEOUT_EN to cover
// the watchdog path.
module tb_pe_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] filBase = 16'h0;
    logic [15:0] imgBase = 16'h0;
    logic [7:0]  numStrips = 8'h0;
    logic        memReq;
    logic [15:0] memAddr;
    logic        memAck = 1'b0;
    logic        mbcZero, raDone, rbFull;
    logic fblRst, fblAct, filBufRst, filBufLd, fillBufISel, mbRst, mbShift, mbWrite;
    logic mblRst, mblAct, mbcRst, mbcEn, wbRst, wbLd, raAct, macRst, macAct;
    logic rbRst, rbEn, macClear, rbClear, resValid, busy, done, err;
    logic        resReady = 1'b1;

    int tests_run = 0;
    int tests_failed = 0;

    // responder / datapath model controls
    bit ack_en = 1'b1;
    bit stray_ack = 1'b0;
    int gap_max = 0;
    int gap_left = 0;
    int mbc_zero_at = 0;

    pe_sequencer #(.ADDR_W(16), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .filBase(filBase), .imgBase(imgBase), .numStrips(numStrips),
        .memReq(memReq), .memAddr(memAddr), .memAck(memAck),
        .mbcZero(mbcZero), .raDone(raDone), .rbFull(rbFull),
        .fblRst(fblRst), .fblAct(fblAct), .filBufRst(filBufRst), .filBufLd(filBufLd),
        .fillBufISel(fillBufISel), .mbRst(mbRst), .mbShift(mbShift), .mbWrite(mbWrite),
        .mblRst(mblRst), .mblAct(mblAct), .mbcRst(mbcRst), .mbcEn(mbcEn),
        .wbRst(wbRst), .wbLd(wbLd), .raAct(raAct), .macRst(macRst), .macAct(macAct),
        .rbRst(rbRst), .rbEn(rbEn), .macClear(macClear), .rbClear(rbClear),
        .resValid(resValid), .resReady(resReady), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [26:0] all_out;
    logic [7:0]  rst8;
    assign all_out = {memReq, |memAddr, fblRst, fblAct, filBufRst, filBufLd, fillBufISel,
                      mbRst, mbShift, mbWrite, mblRst, mblAct, mbcRst, mbcEn, wbRst, wbLd,
                      raAct, macRst, macAct, rbRst, rbEn, macClear, rbClear,
                      resValid, busy, done, err};
    assign rst8 = {fblRst, filBufRst, mbRst, mblRst, mbcRst, wbRst, macRst, rbRst};

    // Datapath stand-in: raDone on the 16th MAC step, rbFull after 4 pushes.
    logic [3:0] mac_cnt;
    logic [2:0] rb_cnt;
    int         sh_cnt;
    assign raDone  = (mac_cnt == 4'd15);
    assign rbFull  = (rb_cnt == 3'd4);
    assign mbcZero = (mbc_zero_at != 0) && (sh_cnt == mbc_zero_at);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_cnt <= 4'd0;
            rb_cnt  <= 3'd0;
            sh_cnt  <= 0;
        end else begin
            if (macRst || macClear) mac_cnt <= 4'd0;
            else if (macAct)        mac_cnt <= mac_cnt + 4'd1;
            if (rbRst || rbClear)   rb_cnt <= 3'd0;
            else if (rbEn)          rb_cnt <= rb_cnt + 3'd1;
            if (mbcRst || mblRst)   sh_cnt <= 0;
            else if (mbcEn)         sh_cnt <= sh_cnt + 1;
        end
    end

    // Memory responder: one ack per request after a 0..gap_max cycle gap.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ack_en && memReq && rst) begin
                if (gap_left == 0) begin
                    memAck = 1'b1;
                    gap_left = $urandom_range(gap_max, 0);
                end else begin
                    memAck = 1'b0;
                    gap_left = gap_left - 1;
                end
            end else begin
                memAck = stray_ack;
            end
        end
    end

    // Event monitor, sampled on the falling edge.
    logic [15:0] addr_log [0:63];
    int addr_n = 0, n_win = 0, n_mac = 0, n_push = 0, n_done = 0, n_rbclr = 0, n_req = 0;
    int run_len = 0, mac_bad = 0, addr_viol = 0, drop_viol = 0;
    logic prev_req = 1'b0, prev_ack = 1'b0, prev_abort = 1'b0;
    logic [15:0] prev_addr = 16'h0;

    always @(negedge clk) begin
        if (!rst) begin
            run_len  <= 0;
            prev_req <= 1'b0;
        end else begin
            if (memReq && memAck) begin
                addr_log[addr_n & 63] <= memAddr;
                addr_n <= addr_n + 1;
            end
            if (prev_req && !prev_ack && memReq && (memAddr != prev_addr)) addr_viol <= addr_viol + 1;
            if (prev_req && !prev_ack && !memReq && !prev_abort && !err) drop_viol <= drop_viol + 1;
            if (macAct) run_len <= run_len + 1;
            else if (run_len != 0) begin
                if (run_len != 16) mac_bad <= mac_bad + 1;
                run_len <= 0;
            end
            n_win   <= n_win + int'(wbLd);
            n_mac   <= n_mac + int'(macAct);
            n_push  <= n_push + int'(rbEn);
            n_done  <= n_done + int'(done);
            n_rbclr <= n_rbclr + int'(rbClear);
            n_req   <= n_req + int'(memReq);
            prev_req   <= memReq;
            prev_ack   <= memAck;
            prev_abort <= abort;
            prev_addr  <= memAddr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] fb, input logic [15:0] ib, input logic [7:0] ns);
        filBase = fb;
        imgBase = ib;
        numStrips = ns;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget && busy; i++) tick();
        check(tag, busy, 0);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    int a0, w0, m0, p0, d0, c0, r0, b0, v0, x0, bad;

    task automatic snap();
        a0 = addr_n; w0 = n_win; m0 = n_mac; p0 = n_push; d0 = n_done;
        c0 = n_rbclr; r0 = n_req; b0 = mac_bad; v0 = addr_viol; x0 = drop_viol;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        #3 rst = 1'b0;
        repeat (3) tick();
        check("reset_outputs", all_out, 27'd0);
        rst = 1'b1;
        tick();

        // 1: reset in the middle of a MAC run, then restart from IDLE
        pulse_start(16'h1000, 16'h2000, 8'd1);
        for (int i = 0; i < 100 && !macAct; i++) tick();
        check("t1_mac_reached", macAct, 1);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("t1_async_outputs", all_out, 27'd0);
        tick();
        rst = 1'b1;
        tick();
        pulse_start(16'h1000, 16'h2000, 8'd1);
        check("t1_restart_busy", busy, 1);
        wait_idle(1000, "t1_job_end");

        // 2: one strip, ack every cycle
        snap();
        pulse_start(16'h1000, 16'h2000, 8'd1);
        wait_idle(1000, "t2_job_end");
        check("t2_acks", addr_n - a0, 8);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_fil_addr%0d", k), addr_log[(a0 + k) & 63], 32'h1000 + k);
            check($sformatf("t2_img_addr%0d", k), addr_log[(a0 + 4 + k) & 63], 32'h2000 + k);
        end
        check("t2_win", n_win - w0, 4);
        check("t2_mac_cycles", n_mac - m0, 64);
        check("t2_mac_run_len", mac_bad - b0, 0);
        check("t2_push", n_push - p0, 4);
        check("t2_rbclear", n_rbclr - c0, 1);
        check("t2_done", n_done - d0, 1);

        // pointer wrap at the top of the address space
        snap();
        pulse_start(16'hFFFE, 16'hFFFF, 8'd1);
        wait_idle(1000, "wrap_job_end");
        check("wrap_fil2", addr_log[(a0 + 2) & 63], 32'h0000);
        check("wrap_fil3", addr_log[(a0 + 3) & 63], 32'h0001);
        check("wrap_img1", addr_log[(a0 + 5) & 63], 32'h0000);

        // 4: zero strips, stray acks present but no request
        snap();
        stray_ack = 1'b1;
        pulse_start(16'h3000, 16'h4000, 8'd0);
        check("t4_init_busy", busy, 1);
        check("t4_init_no_done", done, 0);
        tick();
        check("t4_done_pulse", done, 1);
        tick();
        check("t4_done_low", done, 0);
        check("t4_idle", busy, 0);
        check("t4_no_request", n_req - r0, 0);
        check("t4_no_filter_load", addr_n - a0, 0);
        stray_ack = 1'b0;

        // 3: consumer stall in OUT; rbFull and mbcZero coincide on the last NXT
        snap();
        mbc_zero_at = 3;
        resReady = 1'b0;
        pulse_start(16'h3000, 16'h4000, 8'd1);
        for (int i = 0; i < 500 && !resValid; i++) tick();
        check("t3_resvalid", resValid, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!resValid || rbClear) bad++;
        end
        check("t3_hold", bad, 0);
        resReady = 1'b1;
        #1;
        check("t3_rbclear_on", rbClear, 1);
        tick();
        check("t3_rbclear_off", rbClear, 0);
        check("t3_done", done, 1);
        wait_idle(100, "t3_job_end");
        check("t3_acks_no_refill", addr_n - a0, 8);
        check("t3_rbclear_count", n_rbclr - c0, 1);

        // 5: random ack gaps, two strips, refill after the third window
        snap();
        mbc_zero_at = 2;
        gap_max = 5;
        pulse_start(16'h0100, 16'h0800, 8'd2);
        wait_idle(3000, "t5_job_end");
        check("t5_acks", addr_n - a0, 20);
        bad = 0;
        for (int k = 0; k < 4; k++) if (addr_log[(a0 + k) & 63] != 16'h0100 + 16'(k)) bad++;
        for (int k = 0; k < 16; k++) if (addr_log[(a0 + 4 + k) & 63] != 16'h0800 + 16'(k)) bad++;
        check("t5_addr_seq", bad, 0);
        check("t5_addr_stable", addr_viol - v0, 0);
        check("t5_req_held", drop_viol - x0, 0);
        check("t5_win", n_win - w0, 8);
        check("t5_mac_cycles", n_mac - m0, 128);
        check("t5_mac_run_len", mac_bad - b0, 0);
        check("t5_push", n_push - p0, 8);
        check("t5_results", n_rbclr - c0, 2);
        check("t5_done", n_done - d0, 1);
        gap_max = 0;
        mbc_zero_at = 0;

        // 6: abort while stalled in MBF
        snap();
        pulse_start(16'h5000, 16'h6000, 8'd1);
        for (int i = 0; i < 100 && !(memReq && memAddr == 16'h6000); i++) tick();
        ack_en = 1'b0;
        tick();
        tick();
        check("t6_in_mbf", memReq, 1);
        do_abort();
        check("t6_idle", busy, 0);
        check("t6_req_dropped", memReq, 0);
        check("t6_rst_pulse", rst8, 8'hFF);
        tick();
        check("t6_rst_pulse_end", rst8, 8'h00);
        repeat (5) tick();
        check("t6_no_done", n_done - d0, 0);

        // watchdog (or indefinite wait when it is not built)
        pulse_start(16'h7000, 16'h7800, 8'd1);
        tick();
        check("t6_fil_req", memReq, 1);
`ifdef PE_SEQ_TIMEOUT_EN
        repeat (7) tick();
        check("t6_err_before", err, 0);
        check("t6_req_before", memReq, 1);
        tick();
        check("t6_err_set", err, 1);
        check("t6_timeout_idle", busy, 0);
        check("t6_timeout_req", memReq, 0);
        repeat (3) tick();
        check("t6_err_sticky", err, 1);
        pulse_start(16'h7000, 16'h7800, 8'd1);
        check("t6_err_cleared", err, 0);
        do_abort();
`else
        repeat (40) tick();
        check("t6_still_waiting", memReq, 1);
        check("t6_still_busy", busy, 1);
        check("t6_err_tied", err, 0);
        do_abort();
        check("t6_abort_idle", busy, 0);
`endif
        ack_en = 1'b1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
